// File: rtl/pow_pkg.sv
// pow_pkg: shared constants, state encoding and IEEE-754 rounding helper for the power unit
package pow_pkg;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int ST_INV = 0;
  localparam int ST_DZ  = 1;
  localparam int ST_OVF = 2;
  typedef enum logic [3:0] {
    IDLE, CHECK, MUL_ISSUE, MUL_WAIT, SQ_ISSUE, SQ_WAIT, RECIP_ISSUE, RECIP_WAIT, DONE
  } state_e;
  // round-to-nearest-even; underflow flushes to zero, overflow saturates to Inf
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [11:0] e,
                                          input logic [22:0] f, input logic g, input logic st);
    logic [23:0] r;
    logic signed [11:0] er;
    r = {1'b0, f} + 24'(g & (st | f[0]));
    er = e + $signed({11'b0, r[23]});
    return er >= 255 ? {s, FP_PINF[30:0]} : er <= 0 ? {s, 31'b0} : {s, er[7:0], r[22:0]};
  endfunction
endpackage

// File: rtl/divider.sv
// divider: single-precision divide core (z = a / b), operands latched on stb, result held until ack
module divider
  import pow_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  logic [49:0] num;
  logic [26:0] q;
  logic [25:0] qn;
  logic signed [11:0] e;
  logic [31:0] z;
  logic s, a_nan, b_nan, a_inf, b_inf, a_z, b_z, rem;
  always_comb begin
    s = input_a[31] ^ input_b[31];
    a_nan = &input_a[30:23] && |input_a[22:0];
    b_nan = &input_b[30:23] && |input_b[22:0];
    a_inf = &input_a[30:23] && ~|input_a[22:0];
    b_inf = &input_b[30:23] && ~|input_b[22:0];
    a_z = ~|input_a[30:23];
    b_z = ~|input_b[30:23];
    num = {1'b1, input_a[22:0], 26'b0};
    q = b_z ? '0 : 27'(num / 50'({1'b1, input_b[22:0]}));
    rem = b_z ? 1'b0 : |(num % 50'({1'b1, input_b[22:0]}));
    qn = q[26] ? q[25:0] : {q[24:0], 1'b0};
    e = 12'(input_a[30:23]) - 12'(input_b[30:23]) + 12'd126 + 12'(q[26]);
    z = a_nan || b_nan || (a_inf && b_inf) || (a_z && b_z) ? FP_QNAN :
        a_inf || b_z ? {s, FP_PINF[30:0]} :
        b_inf || a_z ? {s, 31'b0} : fp_pack(s, e, qn[25:3], qn[2], |qn[1:0] | rem);
  end
  always_ff @(posedge clk)
    if (rst) begin
      output_z <= '0;
      output_z_stb <= 1'b0;
    end else if (input_a_stb && input_b_stb) begin
      output_z <= z;
      output_z_stb <= 1'b1;
    end else if (output_z_ack) output_z_stb <= 1'b0;
endmodule

// File: rtl/fp_classify.sv
// fp_classify: IEEE-754 single-precision magnitude classification
module fp_classify (
  input  logic [30:0] mag_i,
  output logic        is_nan_o,
  output logic        is_inf_o,
  output logic        is_zero_o,
  output logic        is_one_mag_o
);
  always_comb begin
    is_nan_o     = &mag_i[30:23] && |mag_i[22:0];
    is_inf_o     = &mag_i[30:23] && ~|mag_i[22:0];
    is_zero_o    = ~|mag_i;
    is_one_mag_o = mag_i == 31'h3F80_0000;
  end
endmodule

// File: rtl/multiplier.sv
// multiplier: single-precision multiply core, operands latched on stb, result held until ack
module multiplier
  import pow_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  logic [47:0] p;
  logic [46:0] pn;
  logic signed [11:0] e;
  logic [31:0] z;
  logic s, a_nan, b_nan, a_inf, b_inf, a_z, b_z;
  always_comb begin
    s = input_a[31] ^ input_b[31];
    a_nan = &input_a[30:23] && |input_a[22:0];
    b_nan = &input_b[30:23] && |input_b[22:0];
    a_inf = &input_a[30:23] && ~|input_a[22:0];
    b_inf = &input_b[30:23] && ~|input_b[22:0];
    a_z = ~|input_a[30:23];
    b_z = ~|input_b[30:23];
    p = 48'({1'b1, input_a[22:0]}) * 48'({1'b1, input_b[22:0]});
    pn = p[47] ? p[46:0] : {p[45:0], 1'b0};
    e = 12'(input_a[30:23]) + 12'(input_b[30:23]) + 12'(p[47]) - 12'd127;
    z = a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z) ? FP_QNAN :
        a_inf || b_inf ? {s, FP_PINF[30:0]} :
        a_z || b_z ? {s, 31'b0} : fp_pack(s, e, pn[46:24], pn[23], |pn[22:0]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      output_z <= '0;
      output_z_stb <= 1'b0;
    end else if (input_a_stb && input_b_stb) begin
      output_z <= z;
      output_z_stb <= 1'b1;
    end else if (output_z_ack) output_z_stb <= 1'b0;
endmodule

// File: rtl/pow_int_unit.sv
// pow_int_unit: IEEE-754 single-precision base^n for a signed integer n,
// square-and-multiply on time-shared multiplier/divider cores
module pow_int_unit
  import pow_pkg::*;
#(
  parameter int EXP_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             data_valid,
  input  logic [31:0]      base_a,
  input  logic [EXP_W-1:0] exponent_n,
  input  logic [TAG_W-1:0] tag_in,
  output logic             calc_done,
  input  logic             read_done,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] tag_out,
  output logic [2:0]       status
);
  state_e state_q, state_d;
  logic [31:0] base_q, acc_q, acc_d, b_q, b_d, result_q, result_d, mul_a, mul_z, div_z, exit_mag;
  logic [EXP_W-1:0] n_q, m_q, m_d, m_abs;
  logic [TAG_W-1:0] tag_q, tag_out_q;
  logic [2:0] status_q, status_d;
  logic neg, nz, sgn, sp, inv, z_inf, done_in, rst;
  logic c_nan, c_inf, c_zero, c_one, mul_stb, div_stb, mul_zs, div_zs, mul_ack, div_ack;

  fp_classify u_cls (
    .mag_i(base_q[30:0]), .is_nan_o(c_nan), .is_inf_o(c_inf), .is_zero_o(c_zero), .is_one_mag_o(c_one)
  );

  multiplier u_mul (
    .clk, .rst, .input_a(mul_a), .input_a_stb(mul_stb), .input_b(b_q), .input_b_stb(mul_stb),
    .output_z(mul_z), .output_z_stb(mul_zs), .output_z_ack(mul_ack)
  );

  divider u_div (
    .clk, .rst, .input_a(FP_ONE), .input_a_stb(div_stb), .input_b(acc_q), .input_b_stb(div_stb),
    .output_z(div_z), .output_z_stb(div_zs), .output_z_ack(div_ack)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    neg = n_q[EXP_W-1];
    nz = |n_q;
    sgn = base_q[31] & n_q[0];
    m_abs = neg ? -n_q : n_q;
    z_inf = &mul_z[30:23];
    exit_mag = neg ? FP_ZERO : FP_PINF;
    sp = !nz || c_nan || c_zero || c_inf || c_one || n_q == EXP_W'(1);
    state_d = state_q;
    acc_d = acc_q;
    b_d = b_q;
    m_d = m_q;
    case (state_q)
      IDLE: if (data_valid) state_d = CHECK;
      CHECK: begin
        acc_d = !nz ? FP_ONE : c_nan ? FP_QNAN : c_zero ? (neg ? FP_PINF : FP_ZERO) :
                c_inf ? exit_mag : c_one ? FP_ONE : n_q == EXP_W'(1) ? {1'b0, base_q[30:0]} : FP_ONE;
        b_d = {1'b0, base_q[30:0]};
        m_d = m_abs[0] ? m_abs : m_abs >> 1;
        state_d = sp ? DONE : m_abs[0] ? MUL_ISSUE : SQ_ISSUE;
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT: if (mul_zs) begin
        acc_d = z_inf ? exit_mag : mul_z;
        m_d = m_q >> 1;
        state_d = z_inf ? DONE : |m_d ? SQ_ISSUE : neg ? RECIP_ISSUE : DONE;
      end
      SQ_ISSUE: state_d = SQ_WAIT;
      SQ_WAIT: if (mul_zs) begin
        b_d = mul_z;
        acc_d = z_inf ? exit_mag : acc_q;
        m_d = m_q[0] ? m_q : m_q >> 1;
        state_d = z_inf ? DONE : m_q[0] ? MUL_ISSUE : SQ_ISSUE;
      end
      RECIP_ISSUE: state_d = RECIP_WAIT;
      RECIP_WAIT: if (div_zs) begin
        acc_d = div_z;
        state_d = DONE;
      end
      DONE: if (read_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inv = c_nan & nz;
    done_in = state_d == DONE && state_q != DONE;
    result_d = acc_d | {sgn & ~inv, 31'b0};
    status_d = '0;
    status_d[ST_INV] = inv;
    status_d[ST_DZ] = c_zero & neg;
    status_d[ST_OVF] = ~neg & nz & ~c_nan & ~c_inf & ~c_zero & (&acc_d[30:23]);
  end

  always_comb begin
    rst = ~rst_n;
    ready = state_q == IDLE;
    calc_done = state_q == DONE;
    mul_stb = state_q == MUL_ISSUE || state_q == SQ_ISSUE;
    div_stb = state_q == RECIP_ISSUE;
    mul_ack = (state_q == MUL_WAIT || state_q == SQ_WAIT) && mul_zs;
    div_ack = state_q == RECIP_WAIT && div_zs;
    mul_a = state_q == SQ_ISSUE ? b_q : acc_q;
    result = result_q;
    tag_out = tag_out_q;
    status = status_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base_q <= '0;
      n_q <= '0;
      tag_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      m_q <= '0;
      result_q <= '0;
      tag_out_q <= '0;
      status_q <= '0;
    end else begin
      if (state_q == IDLE && data_valid) begin
        base_q <= base_a;
        n_q <= exponent_n;
        tag_q <= tag_in;
      end
      acc_q <= acc_d;
      b_q <= b_d;
      m_q <= m_d;
      if (done_in) begin
        result_q <= result_d;
        tag_out_q <= tag_q;
        status_q <= status_d;
      end
    end
endmodule
